// File: rtl/fsm_convert_float_to_fixed_ctrl_if.sv
// Control/status bundle between the float-to-fixed control FSM, its datapath
// and the top-level sequencer. The FSM connects through the slave modport;
// whoever drives requests and datapath status uses the master modport.
interface fsm_convert_float_to_fixed_ctrl_if;
    // Request side and datapath status
    logic       Begin_FSM_i;
    logic       Exp_out_i;
    logic [7:0] Exp_i;

    // Datapath enables and handshake/status outputs
    logic       EN_REG1;
    logic       LOAD;
    logic       MS_1;
    logic       EN_REG2;
    logic       ACK_FF;
    logic       Busy_o;
    logic       OVF_o;

    modport master (
        output Begin_FSM_i,
        output Exp_out_i,
        output Exp_i,
        input  EN_REG1,
        input  LOAD,
        input  MS_1,
        input  EN_REG2,
        input  ACK_FF,
        input  Busy_o,
        input  OVF_o
    );

    modport slave (
        input  Begin_FSM_i,
        input  Exp_out_i,
        input  Exp_i,
        output EN_REG1,
        output LOAD,
        output MS_1,
        output EN_REG2,
        output ACK_FF,
        output Busy_o,
        output OVF_o
    );
endinterface

// File: rtl/fsm_convert_float_to_fixed_ctrl.sv
// Control FSM for the float-to-fixed conversion datapath. One conversion per
// four-phase Begin/ACK request: load the float register, let the exponent
// comparator settle, pick the shift amount, strobe the barrel shifter, wait
// out its latency, store the fixed-point result and acknowledge.
//
// Every output is a flop. The strobes are decoded from the state register of
// the previous cycle, so each enable appears one cycle after the FSM enters
// the matching state; the whole timeline is shifted uniformly by that cycle.
module fsm_convert_float_to_fixed_ctrl #(
    parameter int SHIFT_LAT  = 1,    // LOAD to shifter-output-valid, 1..7
    parameter int MAX_LSHIFT = 4,    // largest left shift that still fits
    parameter int BIAS       = 127   // single-precision exponent bias
) (
    input logic                            CLK,
    input logic                            RST,
    fsm_convert_float_to_fixed_ctrl_if.slave ctrl_if
);

    // Exponent constants in datapath widths. The overflow limit is 9 bits
    // wide so BIAS+MAX_LSHIFT can never wrap against an 8-bit exponent.
    localparam logic [7:0] BIAS_EXP  = 8'(BIAS);
    localparam logic [8:0] OVF_LIMIT = 9'(BIAS + MAX_LSHIFT);
    localparam logic [7:0] EXP_INF   = 8'hFF;
    localparam logic [2:0] LAT_LOAD  = 3'(SHIFT_LAT);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_FLOAT = 3'd1,
        WAIT_CMP   = 3'd2,
        SEL_SHIFT  = 3'd3,
        LOAD_SHIFT = 3'd4,
        WAIT_SHIFT = 3'd5,
        STORE      = 3'd6,
        DONE       = 3'd7
    } state_t;

    state_t     state_q,   state_d;
    logic [2:0] cnt_q,     cnt_d;
    logic       en_reg1_q, en_reg1_d;
    logic       load_q,    load_d;
    logic       ms_1_q,    ms_1_d;
    logic       en_reg2_q, en_reg2_d;
    logic       ack_q,     ack_d;
    logic       busy_q,    busy_d;
    logic       ovf_q,     ovf_d;

    // Sampled in SEL_SHIFT. A left shift can only overflow when the
    // comparator reports an exponent above the bias; an all-ones exponent
    // (Inf/NaN) never fits regardless of the comparator.
    logic exp_is_biased_one;
    logic exp_overflows;

    assign exp_is_biased_one = (ctrl_if.Exp_i == BIAS_EXP);
    assign exp_overflows     = (ctrl_if.Exp_out_i && ({1'b0, ctrl_if.Exp_i} > OVF_LIMIT))
                             || (ctrl_if.Exp_i == EXP_INF);

    // Next-state, latency counter and registered-output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ms_1_d    = ms_1_q;
        ovf_d     = ovf_q;
        ack_d     = 1'b0;
        // Single-cycle strobes follow the state held during this cycle.
        en_reg1_d = (state_q == LOAD_FLOAT);
        load_d    = (state_q == LOAD_SHIFT);
        en_reg2_d = (state_q == STORE);
        busy_d    = (state_q != IDLE) && (state_q != DONE);

        case (state_q)
            IDLE: begin
                ms_1_d = 1'b0;
                if (ctrl_if.Begin_FSM_i) begin
                    // A new request starts with a clean overflow flag.
                    ovf_d   = 1'b0;
                    state_d = LOAD_FLOAT;
                end
            end

            LOAD_FLOAT: begin
                state_d = WAIT_CMP;
            end

            WAIT_CMP: begin
                // Float register is valid; comparator is registering.
                state_d = SEL_SHIFT;
            end

            SEL_SHIFT: begin
                // Exponent equal to the bias needs no shift at all; every
                // other exponent (including zero/denormal) shifts by
                // |exp-BIAS| and the shifter sorts out the direction.
                ms_1_d  = !exp_is_biased_one;
                ovf_d   = exp_overflows;
                state_d = LOAD_SHIFT;
            end

            LOAD_SHIFT: begin
                cnt_d   = LAT_LOAD;
                state_d = WAIT_SHIFT;
            end

            WAIT_SHIFT: begin
                // Counter enters at SHIFT_LAT, so this state lasts exactly
                // SHIFT_LAT cycles. The <= guard also covers a corrupted 0.
                if (cnt_q <= 3'd1) begin
                    cnt_d   = 3'd0;
                    state_d = STORE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            STORE: begin
                // Result is stored even when the overflow flag is set.
                state_d = DONE;
            end

            DONE: begin
                ms_1_d = 1'b0;
                if (ctrl_if.Begin_FSM_i) begin
                    ack_d = 1'b1;
                end else begin
                    // ACK drops on the same edge that returns to IDLE, so a
                    // new request is taken one cycle after ACK falls.
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            en_reg1_q <= 1'b0;
            load_q    <= 1'b0;
            ms_1_q    <= 1'b0;
            en_reg2_q <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            en_reg1_q <= en_reg1_d;
            load_q    <= load_d;
            ms_1_q    <= ms_1_d;
            en_reg2_q <= en_reg2_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
        end
    end

    assign ctrl_if.EN_REG1 = en_reg1_q;
    assign ctrl_if.LOAD    = load_q;
    assign ctrl_if.MS_1    = ms_1_q;
    assign ctrl_if.EN_REG2 = en_reg2_q;
    assign ctrl_if.ACK_FF  = ack_q;
    assign ctrl_if.Busy_o  = busy_q;
    assign ctrl_if.OVF_o   = ovf_q;

endmodule

// File: tb/tb_fsm_convert_float_to_fixed_ctrl.sv
// Bench for the float-to-fixed control FSM. Two instances (SHIFT_LAT=1 and
// SHIFT_LAT=3) share clock, reset and exponent inputs; each has its own
// Begin line. Expected outputs come from the published latency timeline,
// counted in cycles after the request-accept edge.
module tb_fsm_convert_float_to_fixed_ctrl;

    logic       clk;
    logic       rst;
    logic       begin_r [2];
    logic [7:0] exp_i_r;
    logic       exp_out_r;

    int n_checks;
    int n_errors;

    // OVF value each instance should be holding while idle.
    logic prev_ovf [2];

    logic [7:0] bnd [8] = '{8'd0, 8'd126, 8'd127, 8'd128, 8'd131, 8'd132, 8'd254, 8'd255};

    fsm_convert_float_to_fixed_ctrl_if if0 ();
    fsm_convert_float_to_fixed_ctrl_if if1 ();

    assign if0.Begin_FSM_i = begin_r[0];
    assign if0.Exp_i       = exp_i_r;
    assign if0.Exp_out_i   = exp_out_r;
    assign if1.Begin_FSM_i = begin_r[1];
    assign if1.Exp_i       = exp_i_r;
    assign if1.Exp_out_i   = exp_out_r;

    fsm_convert_float_to_fixed_ctrl #(.SHIFT_LAT(1), .MAX_LSHIFT(4), .BIAS(127)) dut0 (
        .CLK     (clk),
        .RST     (rst),
        .ctrl_if (if0)
    );

    fsm_convert_float_to_fixed_ctrl #(.SHIFT_LAT(3), .MAX_LSHIFT(4), .BIAS(127)) dut1 (
        .CLK     (clk),
        .RST     (rst),
        .ctrl_if (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector order: {EN_REG1, LOAD, MS_1, EN_REG2, ACK_FF, Busy_o, OVF_o}
    logic [6:0] obs0, obs1;
    assign obs0 = {if0.EN_REG1, if0.LOAD, if0.MS_1, if0.EN_REG2, if0.ACK_FF, if0.Busy_o, if0.OVF_o};
    assign obs1 = {if1.EN_REG1, if1.LOAD, if1.MS_1, if1.EN_REG2, if1.ACK_FF, if1.Busy_o, if1.OVF_o};

    function automatic logic [6:0] obs(input int d);
        return (d == 0) ? obs0 : obs1;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Out of range when the left shift exceeds 4 (exp > 131) or Inf/NaN.
    function automatic logic ovf_rule(input logic [7:0] e);
        return (int'(e) > 127 + 4) || (e == 8'hFF);
    endfunction

    // Expected outputs k cycles after the accept edge, Begin held for ACK.
    function automatic logic [6:0] expv(input int k, input int lat, input logic [7:0] e);
        logic en1, ld, ms, en2, ack, busy, ovf;
        en1  = (k == 1);
        ld   = (k == 4);
        ms   = (k >= 3) && (k <= 5 + lat) && (e != 8'd127);
        en2  = (k == 5 + lat);
        ack  = (k >= 6 + lat);
        busy = (k >= 1) && (k <= 5 + lat);
        ovf  = (k >= 3) && ovf_rule(e);
        return {en1, ld, ms, en2, ack, busy, ovf};
    endfunction

    task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // One full conversion on instance d; Begin is held `hold` extra cycles
    // after ACK rises and toggles randomly while it must be ignored.
    task automatic conv(input int d, input logic [7:0] e, input int hold);
        int   lat;
        int   k_end;
        logic [6:0] idle_v;
        lat       = lat_of(d);
        k_end     = 6 + lat + hold;
        exp_i_r   = e;
        exp_out_r = (e > 8'd127);
        begin_r[d] = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k <= k_end; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            check_eq($sformatf("d%0d e=%0d k=%0d", d, e, k), obs(d), expv(k, lat, e));
            if (k <= 4 + lat)      begin_r[d] = 1'($urandom_range(0, 1));
            else if (k < k_end)    begin_r[d] = 1'b1;
            else                   begin_r[d] = 1'b0;
        end
        idle_v = {6'b0, ovf_rule(e)};
        @(posedge clk); #1;
        check_eq($sformatf("d%0d e=%0d ack_fall", d, e), obs(d), idle_v);
        @(posedge clk); #1;
        check_eq($sformatf("d%0d e=%0d idle", d, e), obs(d), idle_v);
        prev_ovf[d] = ovf_rule(e);
        $display("conv d=%0d lat=%0d exp=%0d hold=%0d ovf=%0b", d, lat, e, hold, ovf_rule(e));
    endtask

    // Reset pulse while instance 1 sits in WAIT_SHIFT, Begin kept high.
    task automatic mid_shift_reset();
        exp_i_r    = 8'd140;
        exp_out_r  = 1'b1;
        begin_r[1] = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_seq k=0", obs(1), expv(0, 3, 8'd140));
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            check_eq($sformatf("rst_seq k=%0d", k), obs(1), expv(k, 3, 8'd140));
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_mid d1", obs(1), 7'b0);
        check_eq("rst_mid d0", obs(0), 7'b0);
        prev_ovf[0] = 1'b0;
        prev_ovf[1] = 1'b0;
        rst = 1'b0;
        $display("reset in WAIT_SHIFT applied");
        conv(1, 8'd127, 0);
    endtask

    initial begin
        int   d;
        int   hold;
        logic [7:0] e;
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        begin_r[0] = 1'b0;
        begin_r[1] = 1'b0;
        exp_i_r    = 8'd0;
        exp_out_r  = 1'b0;
        prev_ovf[0] = 1'b0;
        prev_ovf[1] = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("reset d0", obs(0), 7'b0);
        check_eq("reset d1", obs(1), 7'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("post_reset d0", obs(0), 7'b0);
        check_eq("post_reset d1", obs(1), 7'b0);

        // Directed cases: 1.0, 4.0, 0.5, overflow, clear, long latency.
        conv(0, 8'd127, 0);
        conv(0, 8'd129, 0);
        conv(0, 8'd126, 0);
        conv(0, 8'd150, 0);
        conv(0, 8'd127, 0);
        conv(1, 8'd127, 0);
        conv(1, 8'd200, 0);
        mid_shift_reset();
        conv(0, 8'd127, 5);
        conv(0, 8'd127, 0);

        // Randomized requests over both latencies.
        for (int i = 0; i < 60; i++) begin
            d    = int'($urandom_range(0, 1));
            hold = int'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) e = bnd[$urandom_range(0, 7)];
            else                           e = 8'($urandom);
            conv(d, e, hold);
            check_eq($sformatf("other d%0d idle", 1 - d), obs(1 - d), {6'b0, prev_ovf[1 - d]});
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fsm_convert_float_to_fixed_ctrl.md
Name: fsm_convert_float_to_fixed_ctrl

Overview:
- Control FSM that sequences the float-to-fixed conversion datapath (float register, exponent comparator, barrel shifter, fixed-point output register) for one conversion per request.
- Generates the datapath enables EN_REG1, LOAD, MS_1 and EN_REG2, and waits out the comparator and shifter register latencies.
- Returns a four-phase Begin/ACK handshake to the natural-logarithm top-level sequencer and flags exponents whose shifted result cannot fit the fixed-point format.

Parameters:
- SHIFT_LAT, 1, cycles from the LOAD pulse until barrel shifter output is valid (range 1..7).
- MAX_LSHIFT, 4, largest left shift that keeps the result inside the fixed format; larger exponents flag overflow.
- BIAS, 127, exponent bias of the single-precision input.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- Begin_FSM_i  in  1  conversion request; level, four-phase handshake.
- Exp_out_i  in  1  registered comparator output from the datapath (exponent > BIAS).
- Exp_i  in  8  biased exponent from the datapath float register.
- EN_REG1  out  1  load enable for the float register.
- LOAD  out  1  barrel shifter load strobe.
- MS_1  out  1  shift-amount select: 0 = zero shift, 1 = |exp-BIAS|.
- EN_REG2  out  1  load enable for the fixed-point result register.
- ACK_FF  out  1  conversion done.
- Busy_o  out  1  high while a conversion is in flight.
- OVF_o  out  1  exponent out of range for the fixed format.

Behaviour:
- All state is updated on the rising edge of CLK. RST is sampled only at that edge.
- Reset: state IDLE, latency counter 0. EN_REG1, LOAD, MS_1, EN_REG2, ACK_FF, Busy_o and OVF_o are all 0.
- Outputs are registered, decoded from the state and stored flags; there are no combinational input-to-output paths.
- Each state below lasts exactly 1 cycle unless noted otherwise.
- IDLE:
  - All strobes 0.
  - Begin_FSM_i=1 moves to LOAD_FLOAT and clears OVF_o.
- LOAD_FLOAT: EN_REG1=1 for this one cycle; next state WAIT_CMP.
- WAIT_CMP: all strobes 0; float register is now valid and the comparator is registering. Next state SEL_SHIFT.
- SEL_SHIFT: Exp_i and Exp_out_i are both valid and are sampled here.
  - MS_1 is set to (Exp_i != BIAS).
  - OVF_o is set if Exp_i > BIAS+MAX_LSHIFT or Exp_i==8'hFF.
  - Next state LOAD_SHIFT.
- LOAD_SHIFT: LOAD=1 for one cycle; counter loads SHIFT_LAT. Next state WAIT_SHIFT.
- WAIT_SHIFT: counter decrements once per cycle; the FSM leaves for STORE when the counter reaches 1, so this state lasts SHIFT_LAT cycles.
- STORE: EN_REG2=1 for one cycle; next state DONE.
- DONE:
  - ACK_FF=1; it stays high while Begin_FSM_i=1.
  - When Begin_FSM_i=0, next state IDLE and ACK_FF falls on that edge.
- MS_1 is held constant from SEL_SHIFT through STORE and returns to 0 in IDLE.
- OVF_o is held from SEL_SHIFT until the next accepted request; it does not suppress EN_REG2, and the result is stored regardless.
- Busy_o = 1 in every state except IDLE and DONE.
- Latency: Begin_FSM_i is sampled at IDLE on edge 0. EN_REG1 is high in cycle 1 and EN_REG2 in cycle 5+SHIFT_LAT. ACK_FF rises at edge 6+SHIFT_LAT (7 cycles at default).
- Begin_FSM_i is ignored in every state other than IDLE and DONE; deasserting it mid-conversion does not abort.
- A new request can be accepted no earlier than one cycle after ACK_FF falls, i.e. Begin_FSM_i must be seen low in DONE first.
- RST asserted in any state returns to IDLE with reset output values on that edge, including a mid-shift reset. The datapath registers are reset by the same RST.
- Exp_i==BIAS (value in [1,2)): MS_1=0, shift amount 0, Exp_out_i=0.
- Exp_i==0 (zero/denormal): handled as a right shift by 127 with MS_1=1 and no special case; the shifter produces 0.

Test Plan:
1. FLOAT=32'h3F800000 (1.0, Exp_i=127), Begin held until ACK -> EN_REG1 pulse in cycle 1, MS_1=0, LOAD in cycle 4, EN_REG2 in cycle 6, ACK_FF at edge 7, OVF_o=0.
2. FLOAT=32'h40800000 (4.0, Exp_i=129, Exp_out_i=1) -> MS_1=1 from cycle 3 to 6, OVF_o=0; FLOAT=32'h3F000000 (0.5, Exp_i=126, Exp_out_i=0) -> MS_1=1, OVF_o=0.
3. FLOAT=32'h4B000000 (Exp_i=150) -> OVF_o=1 from cycle 3, EN_REG2 still pulses, ACK_FF at edge 7. A following request with 1.0 clears OVF_o at its accept edge.
4. SHIFT_LAT=3 build, FLOAT=1.0 -> WAIT_SHIFT lasts 3 cycles, EN_REG2 in cycle 8, ACK_FF at edge 9.
5. RST=1 for one cycle while in WAIT_SHIFT -> next edge: all outputs 0, state IDLE. With Begin_FSM_i still high, a fresh sequence starts with EN_REG1 one cycle after RST drops.
6. Begin_FSM_i kept high 5 cycles after ACK_FF -> ACK_FF stays 1, no second EN_REG1. Begin drops -> ACK_FF=0 next edge. Begin reasserted -> EN_REG1 one cycle later.
